// File: rtl/oled_spi_sink_if.sv
// Panel-side pins of the OLED SPI link: the master drives them, the sink samples them.
// io_cs and io_reset are active-low.
interface oled_spi_sink_if;
  logic io_sclk;
  logic io_sdin;
  logic io_cs;
  logic io_dc;
  logic io_reset;

  modport master (
    output io_sclk,
    output io_sdin,
    output io_cs,
    output io_dc,
    output io_reset
  );

  modport slave (
    input io_sclk,
    input io_sdin,
    input io_cs,
    input io_dc,
    input io_reset
  );
endinterface

// File: rtl/oled_spi_sink.sv
// Passive SSD1306-style SPI sink: oversamples the panel pins, assembles bytes, decodes the
// display commands that matter and turns data bytes into linear framebuffer writes.
module oled_spi_sink #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oled_spi_sink_if.slave        pins,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  output logic                  byte_is_data,
  output logic                  fb_we,
  output logic [9:0]            fb_addr,
  output logic [7:0]            fb_wdata,
  output logic                  display_on,
  output logic [7:0]            contrast,
  output logic                  inverted,
  output logic                  horiz_mode,
  output logic                  frame_done,
  output logic                  proto_err
);

  localparam logic [1:0] StCmd  = 2'd0;
  localparam logic [1:0] StArg1 = 2'd1;
  localparam logic [1:0] StArg2 = 2'd2;

  // Pin vector order {reset, dc, cs, sdin, sclk}; idle levels so reset release is edge-free.
  localparam logic [4:0] SyncRstVal = 5'b10101;

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0] synced;
  logic       sclk_s, sdin_s, cs_s, dc_s, reset_s;
  logic       sclk_prev_q, cs_prev_q;
  logic       strobe, cs_rise;
  logic [7:0] rx_byte;

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [9:0] ptr_q, ptr_d;

  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic       fb_we_q, fb_we_d;
  logic [9:0] fb_addr_q, fb_addr_d;
  logic [7:0] fb_wdata_q, fb_wdata_d;
  logic       display_on_q, display_on_d;
  logic [7:0] contrast_q, contrast_d;
  logic       inverted_q, inverted_d;
  logic       horiz_mode_q, horiz_mode_d;
  logic       frame_done_q, frame_done_d;
  logic       proto_err_q, proto_err_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0],
              {pins.io_reset, pins.io_dc, pins.io_cs, pins.io_sdin, pins.io_sclk}};
  end

  assign synced  = sync_q[SYNC_STAGES-1];
  assign sclk_s  = synced[0];
  assign sdin_s  = synced[1];
  assign cs_s    = synced[2];
  assign dc_s    = synced[3];
  assign reset_s = synced[4];

  assign strobe  = sclk_s & ~sclk_prev_q & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign rx_byte = {shift_q[6:0], sdin_s};

  always_comb begin
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    op_d           = op_q;
    ptr_d          = ptr_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_wdata_d     = fb_wdata_q;
    display_on_d   = display_on_q;
    contrast_d     = contrast_q;
    inverted_d     = inverted_q;
    horiz_mode_d   = horiz_mode_q;
    frame_done_d   = 1'b0;
    proto_err_d    = 1'b0;

    if (!reset_s) begin
      // Panel reset pin: back to power-on state for as long as it is held.
      shift_d        = 8'h00;
      cnt_d          = 3'd0;
      state_d        = StCmd;
      op_d           = 8'h00;
      ptr_d          = 10'd0;
      byte_data_d    = 8'h00;
      byte_is_data_d = 1'b0;
      fb_addr_d      = 10'd0;
      fb_wdata_d     = 8'h00;
      display_on_d   = 1'b0;
      contrast_d     = 8'h7F;
      inverted_d     = 1'b0;
      horiz_mode_d   = 1'b0;
    end else if (cs_rise) begin
      cnt_d       = 3'd0;
      proto_err_d = (cnt_q != 3'd0);
    end else if (strobe) begin
      shift_d = rx_byte;
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_valid_d   = 1'b1;
        byte_data_d    = rx_byte;
        byte_is_data_d = dc_s;
        case (state_q)
          StCmd: begin
            if (dc_s) begin
              fb_we_d      = 1'b1;
              fb_addr_d    = ptr_q;
              fb_wdata_d   = rx_byte;
              frame_done_d = (ptr_q == 10'd1023);
              ptr_d        = ptr_q + 10'd1;
            end else begin
              case (rx_byte)
                8'hAE: display_on_d = 1'b0;
                8'hAF: display_on_d = 1'b1;
                8'hA6: inverted_d   = 1'b0;
                8'hA7: inverted_d   = 1'b1;
                8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D,
                8'h21, 8'h22: begin
                  state_d = StArg1;
                  op_d    = rx_byte;
                end
                default: ;
              endcase
            end
          end
          StArg1: begin
            // Arguments are taken regardless of dc.
            if (op_q == 8'h81) contrast_d = rx_byte;
            if (op_q == 8'h20) horiz_mode_d = (rx_byte[1:0] == 2'b00);
            state_d = (op_q == 8'h21 || op_q == 8'h22) ? StArg2 : StCmd;
          end
          StArg2:  state_d = StCmd;
          default: state_d = StCmd;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= {SYNC_STAGES{SyncRstVal}};
      sclk_prev_q    <= 1'b1;
      cs_prev_q      <= 1'b1;
      shift_q        <= 8'h00;
      cnt_q          <= 3'd0;
      state_q        <= StCmd;
      op_q           <= 8'h00;
      ptr_q          <= 10'd0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= 10'd0;
      fb_wdata_q     <= 8'h00;
      display_on_q   <= 1'b0;
      contrast_q     <= 8'h7F;
      inverted_q     <= 1'b0;
      horiz_mode_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      sclk_prev_q    <= sclk_s;
      cs_prev_q      <= cs_s;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      op_q           <= op_d;
      ptr_q          <= ptr_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_wdata_q     <= fb_wdata_d;
      display_on_q   <= display_on_d;
      contrast_q     <= contrast_d;
      inverted_q     <= inverted_d;
      horiz_mode_q   <= horiz_mode_d;
      frame_done_q   <= frame_done_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_wdata     = fb_wdata_q;
  assign display_on   = display_on_q;
  assign contrast     = contrast_q;
  assign inverted     = inverted_q;
  assign horiz_mode   = horiz_mode_q;
  assign frame_done   = frame_done_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: a command/data vector table plus hand-written sequences
// for framing errors, resets and the full-frame pointer sweep.
module tb_oled_spi_sink;

  logic       clk;
  logic       rst_n;
  logic       byte_valid, byte_is_data, fb_we, display_on, inverted, horiz_mode;
  logic       frame_done, proto_err;
  logic [7:0] byte_data, fb_wdata, contrast;
  logic [9:0] fb_addr;

  oled_spi_sink_if pins ();

  oled_spi_sink #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pins         (pins),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .display_on   (display_on),
    .contrast     (contrast),
    .inverted     (inverted),
    .horiz_mode   (horiz_mode),
    .frame_done   (frame_done),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Pulse monitor, sampled on the falling edge.
  int         n_valid = 0, n_we = 0, n_frame = 0, n_perr = 0;
  logic [7:0] cap_data = 8'h00, cap_wdata = 8'h00;
  logic       cap_dc = 1'b0, frame_we = 1'b0;
  logic [9:0] cap_addr = 10'd0, frame_addr = 10'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        n_valid++;
        cap_data = byte_data;
        cap_dc   = byte_is_data;
      end
      if (fb_we) begin
        n_we++;
        cap_addr  = fb_addr;
        cap_wdata = fb_wdata;
      end
      if (frame_done) begin
        n_frame++;
        frame_addr = fb_addr;
        frame_we   = fb_we;
      end
      if (proto_err) n_perr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each sclk phase lasts 3 clk cycles, the minimum for two sync stages.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc);
    for (int i = 0; i < nbits; i++) begin
      pins.io_sclk = 1'b0;
      pins.io_sdin = b[7-i];
      pins.io_dc   = dc;
      repeat (3) @(negedge clk);
      pins.io_sclk = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       dc;
    logic       we;
    logic [9:0] addr;
    logic [7:0] con;
    logic       disp;
    logic       inv;
    logic       hor;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int v0, w0, p0, f0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              byte   dc    we    addr   contrast disp  inv   horiz
    vecs[0]  = '{8'hAE, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h81, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h7F, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'hA6, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h20, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'hAF, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{8'h81, 1'b0, 1'b0, 10'd0, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{8'h3C, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{8'hA7, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{8'h21, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{8'h00, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{8'h7F, 1'b1, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{8'h55, 1'b1, 1'b1, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{8'h40, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{8'hA8, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{8'h3F, 1'b1, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{8'h20, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{8'h02, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{8'hAA, 1'b1, 1'b1, 10'd1, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{8'h20, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{8'hFC, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[22] = '{8'hA6, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[23] = '{8'h81, 1'b0, 1'b0, 10'd0, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[24] = '{8'h90, 1'b1, 1'b0, 10'd0, 8'h90, 1'b1, 1'b0, 1'b1};

    pins.io_sclk  = 1'b1;
    pins.io_sdin  = 1'b0;
    pins.io_cs    = 1'b1;
    pins.io_dc    = 1'b0;
    pins.io_reset = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_byte_valid", byte_valid, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_display_on", display_on, 0);
    check("rst_contrast", contrast, 8'h7F);
    check("rst_inverted", inverted, 0);
    check("rst_horiz_mode", horiz_mode, 0);
    check("rst_proto_err", n_perr, 0);

    // Command/data vector table.
    pins.io_cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NV; k++) begin
      v0 = n_valid;
      w0 = n_we;
      send_byte(vecs[k].b, vecs[k].dc);
      @(negedge clk);
      check($sformatf("vec%0d_valid", k), n_valid - v0, 1);
      check($sformatf("vec%0d_data", k), cap_data, vecs[k].b);
      check($sformatf("vec%0d_is_data", k), cap_dc, vecs[k].dc);
      check($sformatf("vec%0d_we", k), n_we - w0, vecs[k].we);
      if (vecs[k].we) begin
        check($sformatf("vec%0d_addr", k), cap_addr, vecs[k].addr);
        check($sformatf("vec%0d_wdata", k), cap_wdata, vecs[k].b);
      end
      check($sformatf("vec%0d_contrast", k), contrast, vecs[k].con);
      check($sformatf("vec%0d_display", k), display_on, vecs[k].disp);
      check($sformatf("vec%0d_inverted", k), inverted, vecs[k].inv);
      check($sformatf("vec%0d_horiz", k), horiz_mode, vecs[k].hor);
    end
    pins.io_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("table_no_proto_err", n_perr, 0);

    // Framing error after 5 bits, then a clean 0xAF.
    pins.io_cs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'hAE, 1'b0);
    check("pe_display_off", display_on, 0);
    v0 = n_valid;
    p0 = n_perr;
    send_bits(8'hA8, 5, 1'b0);
    pins.io_cs = 1'b1;
    repeat (6) @(negedge clk);
    check("pe_proto_err", n_perr - p0, 1);
    check("pe_no_valid", n_valid - v0, 0);
    pins.io_cs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'hAF, 1'b0);
    @(negedge clk);
    check("pe_next_valid", n_valid - v0, 1);
    check("pe_next_data", cap_data, 8'hAF);
    check("pe_next_display", display_on, 1);
    pins.io_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("pe_single_err", n_perr - p0, 1);

    // Reset mid-byte: partial byte discarded, no pulses, state restored.
    pins.io_cs = 1'b0;
    repeat (2) @(negedge clk);
    v0 = n_valid;
    p0 = n_perr;
    send_bits(8'hFF, 4, 1'b0);
    rst_n = 1'b0;
    pins.io_cs   = 1'b1;
    pins.io_sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rb_no_valid", n_valid - v0, 0);
    check("rb_no_perr", n_perr - p0, 0);
    check("rb_byte_data", byte_data, 8'h00);
    check("rb_display", display_on, 0);
    check("rb_contrast", contrast, 8'h7F);
    check("rb_horiz", horiz_mode, 0);

    // Reset mid-argument: next byte must be decoded as a fresh command.
    pins.io_cs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h81, 1'b0);
    pulse_rst();
    w0 = n_we;
    send_byte(8'h10, 1'b0);
    @(negedge clk);
    check("ra_contrast", contrast, 8'h7F);
    check("ra_no_write", n_we - w0, 0);
    check("ra_data", cap_data, 8'h10);

    // Full frame sweep.
    f0 = n_frame;
    for (int i = 0; i < 1024; i++) begin
      v0 = n_valid;
      w0 = n_we;
      send_byte(i[7:0], 1'b1);
      @(negedge clk);
      check("sweep_valid", n_valid - v0, 1);
      check("sweep_we", n_we - w0, 1);
      check("sweep_addr", cap_addr, i);
      check("sweep_wdata", cap_wdata, i & 255);
    end
    check("frame_done_once", n_frame - f0, 1);
    check("frame_done_addr", frame_addr, 10'd1023);
    check("frame_done_with_we", frame_we, 1);
    send_byte(8'hC3, 1'b1);
    @(negedge clk);
    check("wrap_addr", cap_addr, 10'd0);
    check("wrap_wdata", cap_wdata, 8'hC3);
    check("wrap_no_frame", n_frame - f0, 1);

    // Panel reset pin after ~300 data bytes.
    send_byte(8'h81, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hAF, 1'b0);
    for (int i = 0; i < 299; i++) send_byte(8'h5A, 1'b1);
    @(negedge clk);
    check("pr_pre_addr", cap_addr, 10'd299);
    check("pr_pre_contrast", contrast, 8'h3C);
    check("pr_pre_display", display_on, 1);
    pins.io_reset = 1'b0;
    repeat (10) @(negedge clk);
    pins.io_reset = 1'b1;
    repeat (4) @(negedge clk);
    check("pr_contrast", contrast, 8'h7F);
    check("pr_display", display_on, 0);
    check("pr_fb_addr", fb_addr, 10'd0);
    send_byte(8'h99, 1'b1);
    @(negedge clk);
    check("pr_next_addr", cap_addr, 10'd0);
    check("pr_next_wdata", cap_wdata, 8'h99);
    pins.io_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("total_proto_err", n_perr, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
